hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard controller for the in-order pipeline. It keeps a shadow copy of destination-register metadata for every stage after decode, and from it drives four things: RAW forwarding selects for decode's operand muxes, load-use stall, branch/jump redirect flush, and bubble insertion. It sits between the decode pipeline register and the fetch/decode/execute pipeline registers of the pipeline top. It is what makes back-to-back dependent instructions execute correctly.

## Interface

Parameters:
- REG_ADDR_W, 5, register-index width
- PIPE_DEPTH, 3, tracked stages after decode; stage 1 = Exec … stage PIPE_DEPTH = WB
- LOAD_STAGE, 2, first stage whose output carries load data
- REDIRECT_STAGE, 2, stage that resolves taken branch/jump; range 1..PIPE_DEPTH-1
- SEL_W, $clog2(PIPE_DEPTH+1), forward-select width

Ports (one clock `clk`; reset `rstn` is synchronous and active-low):
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous active-low reset
- dec_valid  in  1  decode register holds a live instruction
- dec_rs1, dec_rs2  in  REG_ADDR_W  source indices
- dec_rs1_used, dec_rs2_used  in  1  source is actually read
- dec_rd  in  REG_ADDR_W  destination index
- dec_wr_en  in  1  instruction writes dec_rd
- dec_is_load  in  1  instruction is a load
- redirect  in  1  taken branch/jump at REDIRECT_STAGE this cycle
- stall_if_dec  out  1  hold PC and IF/Dec register
- flush_if_dec  out  1  kill IF/Dec register contents
- flush_mask  out  PIPE_DEPTH  bit k-1 kills stage k
- fwd_rs1_sel, fwd_rs2_sel  out  SEL_W  0 = register file, k = result of stage k

## Operation

- Shadow entry per stage k: {v, rd, we, ld}. An entry is a producer for source s when v & we & rd==s & s!=0.
- Per source (used, dec_valid=1): match = the lowest k (youngest) producer. Unused sources, s==0, and dec_valid=0 never match.
- Forwarding built (see Configuration):
  - match at k with ld=1 and k<LOAD_STAGE → stall.
  - any other match → fwd_sel=k.
  - no match → 0.
- stall_if_dec = OR of both sources' stall conditions, qualified by !redirect.
- Redirect overrides everything:
  - flush_if_dec=1, stall_if_dec=0.
  - flush_mask bits for stages 1..REDIRECT_STAGE-1 = 1; all other bits 0.
- Shadow update each cycle:
  - entry[1] ← bubble (v=0) if stall_if_dec, redirect, or !dec_valid; otherwise the decode metadata.
  - entry[k] ← entry[k-1] for k=2..PIPE_DEPTH, with v cleared where flush_mask bit k-2 is set.
  - The WB entry retires.
- Register file is write-first. A producer in stage PIPE_DEPTH therefore never stalls, and its select is PIPE_DEPTH only under forwarding.

## Timing

- All outputs are combinational from the registered shadow plus the current dec_*/redirect inputs. No added latency.
- Shadow updates on the rising clk edge.
- Reset (rstn=0 sampled at the edge):
  - every entry v=0.
  - while rstn=0, all outputs forced 0: stall_if_dec=0, flush_if_dec=0, flush_mask=0, fwd_*_sel=0.
- Reset mid-stall: the stall releases on the first cycle after reset. The held instruction is dropped by the pipeline registers' own reset.
- Load-use with LOAD_STAGE=2: exactly 1 stall cycle, then fwd_sel=2.
- Simultaneous stall + redirect: redirect wins. No stall, and a bubble enters stage 1.
- Matches on both sources: the selects are independent, and one stall covers both.

## Configuration

- HAZARD_FORWARDING_EN defined: forwarding as above.
- HAZARD_FORWARDING_EN undefined:
  - fwd_*_sel tied 0.
  - any match in stages 1..PIPE_DEPTH-1 stalls, regardless of ld.
  - stalls persist until the producer reaches WB (write-first).

## Structure

- Package hazard_pkg holds:
  - the shadow-entry struct {v, rd, we, ld}
  - constant FWD_RF=0
  - a bubble-entry constant
- Sub-module hazard_match: priority encoder over PIPE_DEPTH entries for one source; outputs hit, stage index, and the ld of the hit. Instantiated twice, once per source.

## Test plan

- add x5 then add x7,x5,x1 back-to-back → fwd_rs1_sel=1, stall_if_dec=0.
- lw x6 then add x8,x6,x6 → 1 cycle stall_if_dec=1 with a bubble entering Exec; next cycle fwd_rs1_sel=fwd_rs2_sel=2.
- addi x0,x0,1 then read x0 → fwd sels 0, no stall.
- Load-use stall pending plus redirect=1 → stall_if_dec=0, flush_if_dec=1, flush_mask=3'b001; next cycle entries 1 and 2 have v=0.
- x9 written at stage 1 and stage 2, consumer reads x9 → fwd_rs1_sel=1.
- HAZARD_FORWARDING_EN undefined: add x5 then use x5 → stall for 2 cycles, fwd sels stay 0, proceeds on the 3rd cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: shadow entry, bubble, select constants.
package hazard_pkg;

    localparam int RD_MAX_W = 8;
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic                v;
        logic [RD_MAX_W-1:0] rd;
        logic                we;
        logic                ld;
    } shadow_t;

    localparam shadow_t BUBBLE = '{v: 1'b0, rd: '0, we: 1'b0, ld: 1'b0};

    function automatic logic is_producer(
        input shadow_t             e,
        input logic [RD_MAX_W-1:0] s
    );
        return e.v & e.we & (e.rd == s);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer priority encoder over the shadow entries for one source.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  shadow_t [PIPE_DEPTH-1:0] entries,
    input  logic [RD_MAX_W-1:0]      src,
    input  logic                     src_live,
    output logic                     hit,
    output logic [SEL_W-1:0]         stage,
    output logic                     ld
);

    // Scan oldest to youngest so the youngest producer wins.
    always_comb begin
        hit   = 1'b0;
        stage = '0;
        ld    = 1'b0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (src_live && is_producer(entries[k], src)) begin
                hit   = 1'b1;
                stage = SEL_W'(k + 1);
                ld    = entries[k].ld;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, redirect flush, bubbles.
// Define HAZARD_FORWARDING_EN to enable operand forwarding; otherwise RAW stalls.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int PIPE_DEPTH     = 3,
    parameter int LOAD_STAGE     = 2,
    parameter int REDIRECT_STAGE = 2,
    parameter int SEL_W          = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_rs1_used,
    input  logic                  dec_rs2_used,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_wr_en,
    input  logic                  dec_is_load,
    input  logic                  redirect,
    output logic                  stall_if_dec,
    output logic                  flush_if_dec,
    output logic [PIPE_DEPTH-1:0] flush_mask,
    output logic [SEL_W-1:0]      fwd_rs1_sel,
    output logic [SEL_W-1:0]      fwd_rs2_sel
);

    localparam logic [PIPE_DEPTH-1:0] REDIR_MASK =
        PIPE_DEPTH'((1 << (REDIRECT_STAGE - 1)) - 1);

    shadow_t [PIPE_DEPTH-1:0] shadow;
    shadow_t [PIPE_DEPTH-1:0] shadow_nxt;

    logic [RD_MAX_W-1:0] rs1_x;
    logic [RD_MAX_W-1:0] rs2_x;
    logic                live1;
    logic                live2;
    logic                hit1;
    logic                hit2;
    logic                ld1;
    logic                ld2;
    logic [SEL_W-1:0]    stage1;
    logic [SEL_W-1:0]    stage2;
    logic                stall1;
    logic                stall2;
    logic [SEL_W-1:0]    sel1;
    logic [SEL_W-1:0]    sel2;
    logic                stall_raw;
    logic                insert;

    assign rs1_x = RD_MAX_W'(dec_rs1);
    assign rs2_x = RD_MAX_W'(dec_rs2);
    assign live1 = dec_valid & dec_rs1_used & (dec_rs1 != '0);
    assign live2 = dec_valid & dec_rs2_used & (dec_rs2 != '0);

    hazard_match #(.PIPE_DEPTH(PIPE_DEPTH), .SEL_W(SEL_W)) u_match1 (
        .entries  (shadow),
        .src      (rs1_x),
        .src_live (live1),
        .hit      (hit1),
        .stage    (stage1),
        .ld       (ld1)
    );

    hazard_match #(.PIPE_DEPTH(PIPE_DEPTH), .SEL_W(SEL_W)) u_match2 (
        .entries  (shadow),
        .src      (rs2_x),
        .src_live (live2),
        .hit      (hit2),
        .stage    (stage2),
        .ld       (ld2)
    );

`ifdef HAZARD_FORWARDING_EN
    assign stall1 = hit1 & ld1 & (int'(stage1) < LOAD_STAGE);
    assign stall2 = hit2 & ld2 & (int'(stage2) < LOAD_STAGE);
    assign sel1   = (hit1 & ~stall1) ? stage1 : SEL_W'(FWD_RF);
    assign sel2   = (hit2 & ~stall2) ? stage2 : SEL_W'(FWD_RF);
`else
    // Write-first register file: only a producer in WB is safe to read.
    assign stall1 = hit1 & (int'(stage1) < PIPE_DEPTH);
    assign stall2 = hit2 & (int'(stage2) < PIPE_DEPTH);
    assign sel1   = SEL_W'(FWD_RF);
    assign sel2   = SEL_W'(FWD_RF);

    logic unused_cfg;
    assign unused_cfg = ^{ld1, ld2, LOAD_STAGE[0]};
`endif

    assign stall_raw    = stall1 | stall2;
    assign stall_if_dec = rstn & ~redirect & stall_raw;
    assign flush_if_dec = rstn & redirect;
    assign flush_mask   = (rstn & redirect) ? REDIR_MASK : '0;
    assign fwd_rs1_sel  = rstn ? sel1 : '0;
    assign fwd_rs2_sel  = rstn ? sel2 : '0;

    assign insert = stall_raw | redirect | ~dec_valid;

    always_comb begin
        shadow_nxt = shadow;
        if (insert) begin
            shadow_nxt[0] = BUBBLE;
        end else begin
            shadow_nxt[0] = '{v: 1'b1, rd: RD_MAX_W'(dec_rd),
                              we: dec_wr_en, ld: dec_is_load};
        end
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            shadow_nxt[k]   = shadow[k-1];
            shadow_nxt[k].v = shadow[k-1].v & ~flush_mask[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadow <= '{default: BUBBLE};
        end else begin
            shadow <= shadow_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow HAZARD_FORWARDING_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       dec_valid;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic       dec_rs1_used;
    logic       dec_rs2_used;
    logic [4:0] dec_rd;
    logic       dec_wr_en;
    logic       dec_is_load;
    logic       redirect;
    logic       stall_if_dec;
    logic       flush_if_dec;
    logic [2:0] flush_mask;
    logic [1:0] fwd_rs1_sel;
    logic [1:0] fwd_rs2_sel;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2_used (dec_rs2_used),
        .dec_rd       (dec_rd),
        .dec_wr_en    (dec_wr_en),
        .dec_is_load  (dec_is_load),
        .redirect     (redirect),
        .stall_if_dec (stall_if_dec),
        .flush_if_dec (flush_if_dec),
        .flush_mask   (flush_mask),
        .fwd_rs1_sel  (fwd_rs1_sel),
        .fwd_rs2_sel  (fwd_rs2_sel)
    );

    task automatic dec(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld);
        dec_valid    = v;
        dec_rs1      = rs1;
        dec_rs1_used = u1;
        dec_rs2      = rs2;
        dec_rs2_used = u2;
        dec_rd       = rd;
        dec_wr_en    = we;
        dec_is_load  = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        redirect = 1'b0;
        repeat (3) tick();
    endtask

    task automatic chk(input string tag, input logic es, input logic ef,
                       input logic [2:0] em, input logic [1:0] e1,
                       input logic [1:0] e2);
        logic [8:0] obs;
        logic [8:0] exp;
        #1;
        obs = {stall_if_dec, flush_if_dec, flush_mask, fwd_rs1_sel, fwd_rs2_sel};
        exp = {es, ef, em, e1, e2};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b (stall,flush,mask,sel1,sel2)",
                    tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn     = 1'b0;
        redirect = 1'b1;
        dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        chk("reset_outputs", 0, 0, 3'b000, 2'd0, 2'd0);
        tick();
        tick();
        rstn = 1'b1;
        drain();
        chk("idle", 0, 0, 3'b000, 2'd0, 2'd0);

        // add x5 ; add x7,x5,x1
        dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        chk("raw_producer", 0, 0, 3'b000, 2'd0, 2'd0);
        tick();
        dec(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
        chk("raw_stage1", !FWD, 0, 3'b000, FWD ? 2'd1 : 2'd0, 2'd0);
        tick();
        chk("raw_stage2", !FWD, 0, 3'b000, FWD ? 2'd2 : 2'd0, 2'd0);
        tick();
        chk("raw_stage3", 0, 0, 3'b000, FWD ? 2'd3 : 2'd0, 2'd0);
        drain();

        // lw x6 ; add x8,x6,x6
        dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        chk("lw_issue", 0, 0, 3'b000, 2'd0, 2'd0);
        tick();
        dec(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
        chk("load_use_stall", 1, 0, 3'b000, 2'd0, 2'd0);
        tick();
        dec(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
        chk("load_use_fwd", !FWD, 0, 3'b000, FWD ? 2'd2 : 2'd0, FWD ? 2'd2 : 2'd0);
        dec(1'b1, 5'd8, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
        chk("bubble_probe", !FWD, 0, 3'b000, 2'd0, FWD ? 2'd2 : 2'd0);
        tick();
        chk("after_bubble", 0, 0, 3'b000, FWD ? 2'd1 : 2'd0, FWD ? 2'd3 : 2'd0);
        drain();

        // addi x0 ; read x0
        dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
        chk("x0_never_fwd", 0, 0, 3'b000, 2'd0, 2'd0);
        drain();

        // load-use pending plus redirect
        dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        dec(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
        redirect = 1'b1;
        chk("redirect_wins", 0, 1, 3'b001, 2'd0, 2'd0);
        tick();
        redirect = 1'b0;
        dec(1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("redirect_flushed", 0, 0, 3'b000, 2'd0, 2'd0);
        drain();

        // x9 in stage 1 and stage 2
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        tick();
        dec(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd10, 1'b1, 1'b0);
        chk("youngest_wins", !FWD, 0, 3'b000, FWD ? 2'd1 : 2'd0, 2'd0);
        drain();

        // reset during a stall
        dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        dec(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        chk("stall_pre_reset", 1, 0, 3'b000, 2'd0, 2'd0);
        rstn = 1'b0;
        chk("reset_forces_zero", 0, 0, 3'b000, 2'd0, 2'd0);
        tick();
        rstn = 1'b1;
        chk("stall_released", 0, 0, 3'b000, 2'd0, 2'd0);
        drain();

        // invalid decode and unused source never match
        dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        dec(1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
        chk("dec_invalid", 0, 0, 3'b000, 2'd0, 2'd0);
        dec(1'b1, 5'd6, 1'b0, 5'd6, 1'b0, 5'd8, 1'b1, 1'b0);
        chk("src_unused", 0, 0, 3'b000, 2'd0, 2'd0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
